// File: rtl/sfifo_wr_arb_if.sv
// Requester-side bus of the FIFO write arbiter: level requests, packed data slices
// and the one-hot grant that accepts a slice on the current edge.
interface sfifo_wr_arb_if #(
    parameter int NREQ   = 4,
    parameter int FIFO_W = 32
);
    logic [NREQ-1:0]        req;
    logic [NREQ*FIFO_W-1:0] req_wd;
    logic [NREQ-1:0]        gnt;

    modport master (output req, output req_wd, input gnt);
    modport slave  (input req, input req_wd, output gnt);
endinterface

// File: rtl/sfifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO push port among NREQ requesters; grants only when
// a slot is guaranteed, sequences FIFO flushes and keeps sticky overflow/underflow flags.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | normal arbitration; grants issued while the FIFO has room
// S_DRAIN | flush accepted; waiting for an in-flight push to land
// S_FLUSH | fifo_fsh is high for this single cycle
// S_DONE  | waiting for the FIFO to report empty before flush_done
module sfifo_wr_arb #(
    parameter int NREQ     = 4,
    parameter int FIFO_D   = 12,
    parameter int FIFO_W   = 32,
    parameter int FIFO_ADR = $clog2(FIFO_D)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    sfifo_wr_arb_if.slave       req_if,
    input  logic                i_flush_req,
    output logic                o_flush_done,
    output logic                o_busy,
    output logic                o_err_ovf,
    output logic                o_err_udf,
    output logic                o_fifo_we,
    output logic [FIFO_W-1:0]   o_fifo_wd,
    output logic                o_fifo_fsh,
    input  logic                i_fifo_full,
    input  logic [FIFO_ADR:0]   i_fifo_len,
    input  logic                i_fifo_ovf,
    input  logic                i_fifo_udf
);
    localparam int                  PTR_W = $clog2(NREQ);
    localparam logic [FIFO_ADR+1:0] DEPTH = (FIFO_ADR+2)'(FIFO_D);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_fifo_we;
    logic [FIFO_W-1:0]  r_fifo_wd;
    logic               r_fifo_fsh;
    logic               r_flush_done;
    logic               r_err_ovf;
    logic               r_err_udf;

    logic [FIFO_ADR+1:0] w_len_sum;
    logic                w_room;
    logic                w_found;
    logic                w_grant;
    logic [PTR_W-1:0]    w_idx;
    logic [PTR_W-1:0]    w_cand;
    logic [NREQ-1:0]     w_gnt;
    logic                w_fsh_nxt;
    logic                w_done_nxt;

    // A pop landing this cycle is not credited, so the room check is conservative.
    assign w_len_sum = {1'b0, i_fifo_len} + {{(FIFO_ADR+1){1'b0}}, r_fifo_we};
    assign w_room    = (w_len_sum < DEPTH) && !i_fifo_full;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = PTR_W'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req_if.req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign w_grant    = (r_state == S_IDLE) && w_room && w_found && !i_flush_req && !i_rst;
    assign w_gnt      = w_grant ? (NREQ'(1) << w_idx) : '0;
    assign req_if.gnt = w_gnt;

    always_comb begin
        w_state_nxt = r_state;
        w_fsh_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_flush_req) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!r_fifo_we) begin
                    w_state_nxt = S_FLUSH;
                    w_fsh_nxt   = 1'b1;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (i_fifo_len == '0) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_fifo_we    <= 1'b0;
            r_fifo_wd    <= '0;
            r_fifo_fsh   <= 1'b0;
            r_flush_done <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_udf    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fifo_fsh   <= w_fsh_nxt;
            r_flush_done <= w_done_nxt;
            r_fifo_we    <= w_grant;
            if (w_grant) begin
                r_fifo_wd <= req_if.req_wd[w_idx*FIFO_W +: FIFO_W];
                r_ptr     <= (w_idx == PTR_W'(NREQ-1)) ? '0 : w_idx + 1'b1;
            end
            // A new error seen on the flush-entry edge wins over the clear.
            if (i_fifo_ovf)     r_err_ovf <= 1'b1;
            else if (w_fsh_nxt) r_err_ovf <= 1'b0;
            if (i_fifo_udf)     r_err_udf <= 1'b1;
            else if (w_fsh_nxt) r_err_udf <= 1'b0;
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_fifo_we    = r_fifo_we;
    assign o_fifo_wd    = r_fifo_wd;
    assign o_fifo_fsh   = r_fifo_fsh;
    assign o_flush_done = r_flush_done;
    assign o_err_ovf    = r_err_ovf;
    assign o_err_udf    = r_err_udf;
endmodule

// File: tb/tb_sfifo_wr_arb.sv
// Bench for sfifo_wr_arb: directed scenarios plus random traffic against a cycle-level
// reference model; pushes are checked by a scoreboard monitor on the FIFO side.
module tb_sfifo_wr_arb;
    localparam int NREQ     = 4;
    localparam int FIFO_D   = 12;
    localparam int FIFO_W   = 32;
    localparam int FIFO_ADR = $clog2(FIFO_D);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sfifo_wr_arb_if #(.NREQ(NREQ), .FIFO_W(FIFO_W)) req_if ();

    logic              flush_req = 1'b0;
    logic              flush_done, busy, err_ovf, err_udf;
    logic              fifo_we, fifo_fsh;
    logic [FIFO_W-1:0] fifo_wd;
    logic              fifo_full;
    logic [FIFO_ADR:0] fifo_len;
    logic              fifo_ovf = 1'b0;
    logic              fifo_udf = 1'b0;

    sfifo_wr_arb #(.NREQ(NREQ), .FIFO_D(FIFO_D), .FIFO_W(FIFO_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .req_if       (req_if),
        .i_flush_req  (flush_req),
        .o_flush_done (flush_done),
        .o_busy       (busy),
        .o_err_ovf    (err_ovf),
        .o_err_udf    (err_udf),
        .o_fifo_we    (fifo_we),
        .o_fifo_wd    (fifo_wd),
        .o_fifo_fsh   (fifo_fsh),
        .i_fifo_full  (fifo_full),
        .i_fifo_len   (fifo_len),
        .i_fifo_ovf   (fifo_ovf),
        .i_fifo_udf   (fifo_udf)
    );

    logic [FIFO_W-1:0] wd [NREQ];
    always_comb begin
        req_if.req_wd = '0;
        for (int i = 0; i < NREQ; i++) req_if.req_wd[i*FIFO_W +: FIFO_W] = wd[i];
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // FIFO environment: occupancy counter driven from the DUT push and bench pops.
    int f_cnt      = 0;
    int ovf_pushes = 0;
    bit pop_en     = 1'b0;
    bit rst_q      = 1'b0;
    bit ovf_q      = 1'b0;
    bit udf_q      = 1'b0;

    assign fifo_len  = (FIFO_ADR+1)'(f_cnt);
    assign fifo_full = (f_cnt == FIFO_D);

    function automatic int after_pop(input int c, input bit p);
        return (p && c > 0) ? c - 1 : c;
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
        ovf_q <= fifo_ovf;
        udf_q <= fifo_udf;
        if (rst || fifo_fsh) begin
            f_cnt <= 0;
        end else begin
            if (fifo_we && after_pop(f_cnt, pop_en) >= FIFO_D) ovf_pushes <= ovf_pushes + 1;
            f_cnt <= after_pop(f_cnt, pop_en) + ((fifo_we && after_pop(f_cnt, pop_en) < FIFO_D) ? 1 : 0);
        end
    end

    typedef struct {
        int                cyc;
        logic [FIFO_W-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: a flush accepted in cycle F gives busy in F+1..F+3, fifo_fsh in F+2
    // and flush_done in F+4; grants follow round-robin order whenever idle with room.
    int              m_ptr        = 0;
    int              flush_cyc    = -100;
    int              last_gnt_cyc = -100;
    bit              m_err_ovf    = 1'b0;
    bit              m_err_udf    = 1'b0;
    bit              model_on     = 1'b0;
    bit [NREQ-1:0]   granted_now  = '0;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_g;
        int              gi;
        int              c;
        bit              room;
        bit              is_busy;
        if (rst_q) begin
            model_on     = 1'b1;
            m_ptr        = 0;
            flush_cyc    = -100;
            last_gnt_cyc = -100;
            m_err_ovf    = 1'b0;
            m_err_udf    = 1'b0;
            chk("rst_fifo_we", fifo_we, 0);
            chk("rst_fifo_wd", fifo_wd, 0);
            chk("rst_fifo_fsh", fifo_fsh, 0);
        end else if (model_on) begin
            if (ovf_q)                       m_err_ovf = 1'b1;
            else if (cyc == flush_cyc + 2)   m_err_ovf = 1'b0;
            if (udf_q)                       m_err_udf = 1'b1;
            else if (cyc == flush_cyc + 2)   m_err_udf = 1'b0;
        end
        granted_now = '0;
        if (model_on) begin
            is_busy = (cyc > flush_cyc) && (cyc <= flush_cyc + 3);
            chk("busy", busy, is_busy);
            chk("fifo_fsh", fifo_fsh, cyc == flush_cyc + 2);
            chk("flush_done", flush_done, cyc == flush_cyc + 4);
            chk("err_ovf", err_ovf, m_err_ovf);
            chk("err_udf", err_udf, m_err_udf);
            if (!rst) begin
                exp_g = '0;
                gi    = 0;
                room  = (f_cnt + ((last_gnt_cyc == cyc - 1) ? 1 : 0)) < FIFO_D;
                if (!is_busy && room && !flush_req) begin
                    for (int k = 0; k < NREQ; k++) begin
                        c = (m_ptr + k) % NREQ;
                        if (exp_g == '0 && req_if.req[c]) begin
                            exp_g[c] = 1'b1;
                            gi       = c;
                        end
                    end
                end
                chk("gnt", req_if.gnt, exp_g);
                if (exp_g != '0) begin
                    m_ptr        = (gi + 1) % NREQ;
                    last_gnt_cyc = cyc;
                    exp_q.push_back('{cyc + 1, wd[gi]});
                    granted_now  = exp_g;
                end
                if (!is_busy && flush_req) flush_cyc = cyc;
            end
        end
    end

    // Scoreboard monitor on the push side.
    logic [FIFO_W-1:0] m_wd_hold = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_q) m_wd_hold = '0;
        if (model_on) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("push_we", fifo_we, 1);
                chk("push_wd", fifo_wd, e.data);
                m_wd_hold = e.data;
            end else begin
                chk("idle_we", fifo_we, 0);
                chk("hold_wd", fifo_wd, m_wd_hold);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic refresh(input int density, input logic [NREQ-1:0] mask);
        for (int i = 0; i < NREQ; i++) begin
            if (!mask[i]) begin
                req_if.req[i] = 1'b0;
            end else if (granted_now[i] || !req_if.req[i]) begin
                req_if.req[i] = ($urandom_range(0, 99) < density);
                wd[i]         = $urandom;
            end
        end
    endtask

    initial begin
        req_if.req = '0;
        for (int i = 0; i < NREQ; i++) wd[i] = '0;
        tick(3);
        rst = 1'b0;

        // all requesters, empty FIFO: grants 0,1,2,3,0
        req_if.req = '1;
        for (int i = 0; i < NREQ; i++) wd[i] = $urandom;
        repeat (5) begin
            tick(1);
            refresh(100, '1);
        end
        req_if.req = '0;
        pop_en = 1'b1;
        tick(8);
        pop_en = 1'b0;

        // single requester fills the FIFO, then stalls
        req_if.req = 4'b0100;
        wd[2] = $urandom;
        repeat (16) begin
            tick(1);
            refresh(100, 4'b0100);
        end
        chk("fill_len", f_cnt, FIFO_D);
        chk("fill_no_ovf", ovf_pushes, 0);

        // one pop frees one slot and grants resume
        pop_en = 1'b1;
        tick(1);
        pop_en = 1'b0;
        repeat (4) begin
            tick(1);
            refresh(100, 4'b0100);
        end
        chk("refill_len", f_cnt, FIFO_D);
        req_if.req = '0;
        pop_en = 1'b1;
        tick(14);
        pop_en = 1'b0;

        // flush with a push in flight; requester held off until idle
        req_if.req = 4'b0010;
        wd[1] = $urandom;
        tick(1);
        refresh(100, 4'b0010);
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
        repeat (6) begin
            tick(1);
            refresh(100, 4'b0010);
        end
        req_if.req = '0;
        tick(2);

        // sticky overflow cleared by a later flush
        fifo_ovf = 1'b1;
        tick(1);
        fifo_ovf = 1'b0;
        tick(5);
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
        tick(6);

        // underflow arriving on the flush-entry edge survives the clear
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
        fifo_udf  = 1'b1;
        tick(1);
        fifo_udf  = 1'b0;
        tick(6);
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
        tick(6);

        // reset in DONE: pointer back to 0
        req_if.req = 4'b0010;
        wd[1] = $urandom;
        tick(1);
        req_if.req = '0;
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        req_if.req = '1;
        for (int i = 0; i < NREQ; i++) wd[i] = $urandom;
        repeat (6) begin
            tick(1);
            refresh(100, '1);
        end
        req_if.req = '0;
        pop_en = 1'b1;
        tick(10);

        // random traffic
        repeat (600) begin
            tick(1);
            refresh(40, '1);
            pop_en    = ($urandom_range(0, 99) < 35);
            flush_req = ($urandom_range(0, 99) < 3);
            fifo_ovf  = ($urandom_range(0, 99) < 2);
            fifo_udf  = ($urandom_range(0, 99) < 2);
            rst       = ($urandom_range(0, 199) == 0);
        end
        req_if.req = '0;
        flush_req  = 1'b0;
        fifo_ovf   = 1'b0;
        fifo_udf   = 1'b0;
        rst        = 1'b0;
        pop_en     = 1'b1;
        tick(6);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("no_ovf_total", ovf_pushes, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
